// File: rtl/bcd_watch_if.sv
// Control and status bundle between the stopwatch core and its surrounding mux/load logic.
// The master drives the controls and the slave (the counter core) returns the watch value and status.
interface bcd_watch_if;
  logic [1:0]  mode;
  logic [15:0] load_val;
  logic        preset;
  logic        start_stop;
  logic [15:0] count;
  logic        running;
  logic        done;
  logic        tick;

  modport master (
    output mode, load_val, preset, start_stop,
    input  count, running, done, tick
  );

  modport slave (
    input  mode, load_val, preset, start_stop,
    output count, running, done, tick
  );
endinterface

// File: rtl/bcd_watch_counter.sv
// 4-digit BCD stopwatch core: counts up or down one step every TICK_DIV clocks and
// stops at 9999 (up) or 0000 (down).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | preset or reset value loaded, waiting for start_stop
//   RUN   | prescaler advancing, count steps on every prescaler wrap
//   PAUSE | prescaler and count frozen, start_stop resumes
//   DONE  | terminal count reached, held until preset or reset
module bcd_watch_counter #(
  parameter int TICK_DIV = 1000000,
  parameter int TICK_W   = 20
) (
  input  logic       clk,
  input  logic       reset,
  bcd_watch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [15:0]       TERM_UP    = 16'h9999;
  localparam logic [15:0]       TERM_DOWN  = 16'h0000;

  state_t            state;
  state_t            state_next;
  logic [15:0]       count_q;
  logic [TICK_W-1:0] presc_q;
  logic              dir_q;
  logic              tick_q;
  logic              running_q;
  logic              done_q;

  logic [15:0]       count_step;
  logic              step_now;
  logic              unused_mode0;

  assign unused_mode0 = bus.mode[0];

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Non-BCD digits in the preset are clamped to 9 rather than wrapped.
  function automatic logic [15:0] bcd_sat(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [15:0] terminal(input logic down);
    return down ? TERM_DOWN : TERM_UP;
  endfunction

  assign count_step = dir_q ? bcd_dec(count_q) : bcd_inc(count_q);
  // A pause request on the wrap cycle suppresses the step.
  assign step_now   = (state == RUN) && !bus.start_stop && (presc_q == PRESC_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (bus.preset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_stop) begin
            state_next = (count_q == terminal(bus.mode[1])) ? DONE : RUN;
          end
        end
        RUN: begin
          if (bus.start_stop) begin
            state_next = PAUSE;
          end else if (step_now && (count_step == terminal(dir_q))) begin
            state_next = DONE;
          end
        end
        PAUSE: begin
          if (bus.start_stop) begin
            state_next = RUN;
          end
        end
        DONE: state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 16'h0000;
      presc_q   <= '0;
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      running_q <= (state_next == RUN);
      done_q    <= (state_next == DONE);
      tick_q    <= 1'b0;
      if (bus.preset) begin
        count_q <= bcd_sat(bus.load_val);
        presc_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_stop) begin
              dir_q   <= bus.mode[1];
              presc_q <= '0;
            end
          end
          RUN: begin
            if (step_now) begin
              presc_q <= '0;
              count_q <= count_step;
              tick_q  <= 1'b1;
            end else if (!bus.start_stop) begin
              presc_q <= presc_q + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Output assignments
  always_comb begin
    bus.count   = count_q;
    bus.running = running_q;
    bus.done    = done_q;
    bus.tick    = tick_q;
  end

endmodule

// File: tb/tb_bcd_watch_counter.sv
// Bench for the BCD stopwatch core with TICK_DIV=4: directed scenarios push expected
// tick values into a queue that a negedge monitor pops whenever tick is seen.
module tb_bcd_watch_counter;
  localparam int TICK_DIV = 4;
  localparam int TICK_W   = 3;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  bcd_watch_if bus ();

  bcd_watch_counter #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tick must match the oldest expected value
  always @(negedge clk) begin
    if (!reset && bus.tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick: got count %h expected no tick at %0t", bus.count, $time);
      end else begin
        check("tick_count", bus.count, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_preset(input logic [15:0] v);
    @(negedge clk);
    bus.load_val = v;
    bus.preset   = 1'b1;
    @(negedge clk);
    bus.preset   = 1'b0;
  endtask

  task automatic pulse_ss();
    @(negedge clk);
    bus.start_stop = 1'b1;
    @(negedge clk);
    bus.start_stop = 1'b0;
  endtask

  task automatic run_ticks(input int n, input string name);
    int seen;
    int budget;
    seen   = 0;
    budget = n * TICK_DIV + 20;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (bus.tick === 1'b1) seen++;
      budget--;
    end
    if (seen < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d ticks expected %0d", name, seen, n);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.mode       = 2'b00;
    bus.load_val   = 16'h0000;
    bus.preset     = 1'b0;
    bus.start_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", bus.count, 16'h0000);
    check("rst_running", 16'(bus.running), 16'h0);
    check("rst_done", 16'(bus.done), 16'h0);
    check("rst_tick", 16'(bus.tick), 16'h0);
    reset = 1'b0;

    // Basic up count from zero
    pulse_preset(16'h0000);
    for (int v = 1; v <= 3; v++) exp_q.push_back(to_bcd(v));
    pulse_ss();
    check("up_running", 16'(bus.running), 16'h1);
    run_ticks(3, "up");
    check("up_count", bus.count, 16'h0003);

    // Multi-digit carry
    pulse_preset(16'h0099);
    check("preset_idle", 16'(bus.running), 16'h0);
    check("preset_count", bus.count, 16'h0099);
    exp_q.push_back(16'h0100);
    pulse_ss();
    run_ticks(1, "carry");
    check("carry_count", bus.count, 16'h0100);

    // Count down with borrow through to terminal 0000
    pulse_preset(16'h1000);
    bus.mode = 2'b10;
    for (int v = 999; v >= 0; v--) exp_q.push_back(to_bcd(v));
    pulse_ss();
    bus.mode = 2'b00;
    run_ticks(1000, "down");
    check("down_done", 16'(bus.done), 16'h1);
    check("down_running", 16'(bus.running), 16'h0);
    repeat (10) @(negedge clk);
    check("down_hold", bus.count, 16'h0000);

    // Up to terminal 9999, start_stop ignored in DONE
    pulse_preset(16'h9998);
    check("preset_clears_done", 16'(bus.done), 16'h0);
    exp_q.push_back(16'h9999);
    pulse_ss();
    run_ticks(1, "up_term");
    check("up_done", 16'(bus.done), 16'h1);
    pulse_ss();
    pulse_ss();
    repeat (10) @(negedge clk);
    check("done_hold_count", bus.count, 16'h9999);
    check("done_hold_flag", 16'(bus.done), 16'h1);

    // Pause holds the prescaler: paused at prescaler 2, next tick two edges after resume
    pulse_preset(16'h0000);
    exp_q.push_back(16'h0001);
    pulse_ss();
    @(negedge clk);
    pulse_ss();
    check("pause_running", 16'(bus.running), 16'h0);
    repeat (10) @(negedge clk);
    check("pause_count", bus.count, 16'h0000);
    pulse_ss();
    check("resume_running", 16'(bus.running), 16'h1);
    @(negedge clk);
    check("resume_tick_early", 16'(bus.tick), 16'h0);
    @(negedge clk);
    check("resume_tick", 16'(bus.tick), 16'h1);
    check("resume_count", bus.count, 16'h0001);

    // Preset and start_stop together: preset wins, stays IDLE
    @(negedge clk);
    bus.load_val   = 16'h0042;
    bus.preset     = 1'b1;
    bus.start_stop = 1'b1;
    @(negedge clk);
    bus.preset     = 1'b0;
    bus.start_stop = 1'b0;
    check("both_count", bus.count, 16'h0042);
    check("both_running", 16'(bus.running), 16'h0);
    repeat (8) @(negedge clk);
    check("both_idle_count", bus.count, 16'h0042);

    // Saturating preset, then reset during RUN
    pulse_preset(16'hA5F3);
    check("sat_count", bus.count, 16'h9593);
    exp_q.push_back(16'h9594);
    pulse_ss();
    run_ticks(1, "sat_run");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_count", bus.count, 16'h0000);
    check("midrst_running", 16'(bus.running), 16'h0);
    check("midrst_tick", 16'(bus.tick), 16'h0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", 16'(bus.running), 16'h0);

    check("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
